// File: rtl/excp_flush_ctrl.sv
// Exception / interrupt / ERET sequencer: picks one event from WB, pulses a
// registered commit to CP0, flushes the pipe for a fixed time, then redirects IF.
module excp_flush_ctrl #(
  parameter logic [31:0] EXCP_ENTRY   = 32'hbfc00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic        ws_excp_valid,
  input  logic [4:0]  ws_excp_execode,
  input  logic        ws_eret,
  input  logic [31:0] ws_pc,
  input  logic        ws_bd,
  input  logic [31:0] ws_badvaddr,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [7:0]  cause_ip,
  input  logic [31:0] cp0_epc,
  output logic        excp_commit,
  output logic        eret_commit,
  output logic [4:0]  commit_execode,
  output logic        commit_epc_we,
  output logic [31:0] commit_epc,
  output logic        commit_bd,
  output logic        commit_badv_we,
  output logic [31:0] commit_badvaddr,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       int_req;
  logic       exc_req;
  logic       eret_req;
  logic       trigger;

  // Priority int > exc > eret is folded into the request terms themselves.
  assign int_req  = ws_valid & status_ie & ~status_exl & (|(status_im & cause_ip));
  assign exc_req  = ws_valid & ws_excp_valid & ~int_req;
  assign eret_req = ws_valid & ws_eret & ~ws_excp_valid & ~int_req;
  assign trigger  = (state == IDLE) & (int_req | exc_req | eret_req);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_INIT;
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) state_nxt = REDIRECT;
        else             cnt_nxt   = cnt - 4'd1;
      end
      REDIRECT: begin
        if (redirect_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign pipe_flush     = (state == FLUSH);
  assign redirect_valid = (state == REDIRECT);
  assign busy           = (state != IDLE);

  // Pulses and enables are cleared every cycle; data fields hold until the next trigger.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      excp_commit     <= 1'b0;
      eret_commit     <= 1'b0;
      commit_execode  <= 5'h00;
      commit_epc_we   <= 1'b0;
      commit_epc      <= 32'h0;
      commit_bd       <= 1'b0;
      commit_badv_we  <= 1'b0;
      commit_badvaddr <= 32'h0;
      redirect_pc     <= 32'h0;
    end else begin
      excp_commit    <= 1'b0;
      eret_commit    <= 1'b0;
      commit_epc_we  <= 1'b0;
      commit_badv_we <= 1'b0;
      if (trigger) begin
        excp_commit     <= int_req | exc_req;
        eret_commit     <= eret_req;
        commit_execode  <= exc_req ? ws_excp_execode : 5'h00;
        commit_epc_we   <= (int_req | exc_req) & ~status_exl;
        commit_epc      <= ws_bd ? (ws_pc - 32'd4) : ws_pc;
        commit_bd       <= ws_bd;
        commit_badv_we  <= exc_req & ((ws_excp_execode == 5'h04) | (ws_excp_execode == 5'h05));
        commit_badvaddr <= ws_badvaddr;
        redirect_pc     <= eret_req ? cp0_epc : EXCP_ENTRY;
      end
    end
  end

endmodule

// File: tb/tb_excp_flush_ctrl.sv
// Directed bench for excp_flush_ctrl: a vector table for single events plus
// hand sequences for ack stalls, busy masking, back-to-back and async reset.
module tb_excp_flush_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid, ws_excp_valid, ws_eret, ws_bd;
  logic [4:0]  ws_excp_execode;
  logic [31:0] ws_pc, ws_badvaddr, cp0_epc;
  logic        status_ie, status_exl;
  logic [7:0]  status_im, cause_ip;
  logic        excp_commit, eret_commit, commit_epc_we, commit_bd, commit_badv_we;
  logic [4:0]  commit_execode;
  logic [31:0] commit_epc, commit_badvaddr, redirect_pc;
  logic        pipe_flush, redirect_valid, redirect_ack, busy;

  int n_checks = 0;
  int n_fail   = 0;

  excp_flush_ctrl dut (
    .clk(clk), .resetn(resetn),
    .ws_valid(ws_valid), .ws_excp_valid(ws_excp_valid), .ws_excp_execode(ws_excp_execode),
    .ws_eret(ws_eret), .ws_pc(ws_pc), .ws_bd(ws_bd), .ws_badvaddr(ws_badvaddr),
    .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
    .cause_ip(cause_ip), .cp0_epc(cp0_epc),
    .excp_commit(excp_commit), .eret_commit(eret_commit), .commit_execode(commit_execode),
    .commit_epc_we(commit_epc_we), .commit_epc(commit_epc), .commit_bd(commit_bd),
    .commit_badv_we(commit_badv_we), .commit_badvaddr(commit_badvaddr),
    .pipe_flush(pipe_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  logic any_out;
  assign any_out = |{excp_commit, eret_commit, commit_execode, commit_epc_we, commit_epc,
                     commit_bd, commit_badv_we, commit_badvaddr, pipe_flush,
                     redirect_valid, redirect_pc, busy};

  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic        excp_valid;
    logic [4:0]  execode;
    logic        eret;
    logic [31:0] badv;
    logic        ie;
    logic        exl;
    logic [7:0]  im;
    logic [7:0]  ip;
    logic [31:0] epc;
    logic        exp_excp;
    logic        exp_eret;
    logic [4:0]  exp_execode;
    logic [31:0] exp_epc;
    logic        exp_epc_we;
    logic        exp_badv_we;
    logic [31:0] exp_badv;
    logic [31:0] exp_rpc;
    logic        fields;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ws_valid        = 1'b1;
    ws_pc           = v.pc;
    ws_bd           = v.bd;
    ws_excp_valid   = v.excp_valid;
    ws_excp_execode = v.execode;
    ws_eret         = v.eret;
    ws_badvaddr     = v.badv;
    status_ie       = v.ie;
    status_exl      = v.exl;
    status_im       = v.im;
    cause_ip        = v.ip;
    cp0_epc         = v.epc;
  endtask

  task automatic clear_inputs();
    ws_valid        = 1'b0;
    ws_pc           = 32'h0;
    ws_bd           = 1'b0;
    ws_excp_valid   = 1'b0;
    ws_excp_execode = 5'h00;
    ws_eret         = 1'b0;
    ws_badvaddr     = 32'h0;
    status_ie       = 1'b0;
    status_exl      = 1'b0;
    status_im       = 8'h00;
    cause_ip        = 8'h00;
    cp0_epc         = 32'h0;
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
    check($sformatf("v%0d excp_commit", idx), excp_commit, v.exp_excp);
    check($sformatf("v%0d eret_commit", idx), eret_commit, v.exp_eret);
    check($sformatf("v%0d flush1", idx), pipe_flush, 1);
    check($sformatf("v%0d busy", idx), busy, 1);
    if (v.fields) begin
      check($sformatf("v%0d execode", idx), commit_execode, v.exp_execode);
      check($sformatf("v%0d epc", idx), commit_epc, v.exp_epc);
      check($sformatf("v%0d epc_we", idx), commit_epc_we, v.exp_epc_we);
      check($sformatf("v%0d bd", idx), commit_bd, v.bd);
      check($sformatf("v%0d badv_we", idx), commit_badv_we, v.exp_badv_we);
      if (v.exp_badv_we) check($sformatf("v%0d badvaddr", idx), commit_badvaddr, v.exp_badv);
    end
    @(negedge clk);
    check($sformatf("v%0d flush2", idx), pipe_flush, 1);
    check($sformatf("v%0d pulses_low", idx), {excp_commit, eret_commit, commit_epc_we, commit_badv_we}, 0);
    check($sformatf("v%0d no_redirect_yet", idx), redirect_valid, 0);
    @(negedge clk);
    check($sformatf("v%0d flush_done", idx), pipe_flush, 0);
    check($sformatf("v%0d redirect_valid", idx), redirect_valid, 1);
    check($sformatf("v%0d redirect_pc", idx), redirect_pc, v.exp_rpc);
    if (v.fields) check($sformatf("v%0d epc_stable", idx), commit_epc, v.exp_epc);
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    check($sformatf("v%0d idle_after_ack", idx), busy, 0);
    check($sformatf("v%0d redirect_dropped", idx), redirect_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            pc           bd ev code  er badv          ie exl im     ip     epc           excp eret code  exp_epc       ewe bwe exp_badv      rpc           fields
    vecs[0] = '{32'hbfc00100, 0, 1, 5'h04, 0, 32'h00000003, 0, 0, 8'h00, 8'h00, 32'h0,        1, 0, 5'h04, 32'hbfc00100, 1, 1, 32'h00000003, 32'hbfc00380, 1};
    vecs[1] = '{32'hbfc00204, 1, 1, 5'h08, 0, 32'h00001234, 0, 0, 8'h00, 8'h00, 32'h0,        1, 0, 5'h08, 32'hbfc00200, 1, 0, 32'h0,        32'hbfc00380, 1};
    vecs[2] = '{32'hbfc00300, 0, 1, 5'h0c, 0, 32'h0,        1, 0, 8'h80, 8'h80, 32'h0,        1, 0, 5'h00, 32'hbfc00300, 1, 0, 32'h0,        32'hbfc00380, 1};
    vecs[3] = '{32'hbfc00300, 0, 1, 5'h0c, 0, 32'h0,        1, 1, 8'h80, 8'h80, 32'h0,        1, 0, 5'h0c, 32'hbfc00300, 0, 0, 32'h0,        32'hbfc00380, 1};
    vecs[4] = '{32'hbfc00400, 0, 0, 5'h00, 1, 32'h0,        0, 1, 8'h00, 8'h00, 32'hbfc00abc, 0, 1, 5'h00, 32'h0,        0, 0, 32'h0,        32'hbfc00abc, 0};
    vecs[5] = '{32'hbfc00010, 0, 1, 5'h05, 1, 32'h80000001, 0, 0, 8'h00, 8'h00, 32'h12345678, 1, 0, 5'h05, 32'hbfc00010, 1, 1, 32'h80000001, 32'hbfc00380, 1};
    vecs[6] = '{32'hbfc00420, 0, 0, 5'h00, 1, 32'h0,        0, 0, 8'h00, 8'h00, 32'h00400000, 0, 1, 5'h00, 32'h0,        0, 0, 32'h0,        32'h00400000, 0};
    vecs[7] = '{32'h00000000, 1, 0, 5'h00, 0, 32'h0,        1, 0, 8'h01, 8'h01, 32'h0,        1, 0, 5'h00, 32'hfffffffc, 1, 0, 32'h0,        32'hbfc00380, 1};
    vecs[8] = '{32'hbfc00600, 0, 1, 5'h0a, 0, 32'h0,        1, 0, 8'h02, 8'h01, 32'h0,        1, 0, 5'h0a, 32'hbfc00600, 1, 0, 32'h0,        32'hbfc00380, 1};

    resetn = 1'b0;
    redirect_ack = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("reset_outputs_zero", any_out, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_after_reset", busy, 0);

    for (int i = 0; i < 9; i++) run_vector(vecs[i], i);

    // ERET with stalled ack; ack seen during FLUSH must be ignored.
    @(negedge clk);
    drive(vecs[4]);
    @(posedge clk);
    #1 clear_inputs();
    redirect_ack = 1'b1;
    @(negedge clk);
    check("eret_seq pulse", eret_commit, 1);
    check("eret_seq no_excp", excp_commit, 0);
    @(negedge clk);
    check("eret_seq early_ack_ignored", pipe_flush, 1);
    redirect_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("eret_stall%0d valid", k), redirect_valid, 1);
      check($sformatf("eret_stall%0d pc", k), redirect_pc, 32'hbfc00abc);
      check($sformatf("eret_stall%0d busy", k), busy, 1);
    end
    @(negedge clk);
    check("eret_stall still_valid", redirect_valid, 1);
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    check("eret_stall idle", busy, 0);

    // Busy masking, then back-to-back on the first IDLE cycle.
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #1 drive(vecs[8]);
    @(negedge clk);
    check("mask first_commit", excp_commit, 1);
    check("mask first_code", commit_execode, 5'h04);
    @(negedge clk);
    check("mask no_pulse_flush", excp_commit, 0);
    check("mask code_held", commit_execode, 5'h04);
    @(negedge clk);
    check("mask no_pulse_redirect", excp_commit, 0);
    check("mask redirect_valid", redirect_valid, 1);
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    check("b2b idle", busy, 0);
    check("b2b no_pulse_idle", excp_commit, 0);
    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
    check("b2b second_commit", excp_commit, 1);
    check("b2b second_code", commit_execode, 5'h0a);
    check("b2b second_epc", commit_epc, 32'hbfc00600);
    check("b2b flush1", pipe_flush, 1);
    @(negedge clk);
    check("b2b flush2", pipe_flush, 1);
    @(negedge clk);
    check("b2b redirect", redirect_valid, 1);
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
    check("b2b done", busy, 0);

    // Async reset during the second FLUSH cycle.
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #1 clear_inputs();
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 check("async_rst all_zero", any_out, 0);
    @(negedge clk);
    check("async_rst held_zero", any_out, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("async_rst idle", busy, 0);
    check("async_rst no_pulse", excp_commit, 0);
    run_vector(vecs[1], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
